reg_bank_wr_arbiter: RTL and testbench
======================================

// Module: reg_bank_wr_arbiter
// PURPOSE
//   Shares write access to a bank of NREG resettable/enabled 8-bit registers among NREQ requesters.
//   Requesters are selected round-robin. The winner's address and data are latched.
//   The block then drives a one-cycle one-hot reg_en and reg_d into the bank, and returns ack to the winner.
//   An optional lock holds ownership of the bank for back-to-back burst writes.
//   It sits between the requesting control units and the register8 bank. The bank takes its d_in and en directly from this block.
// PARAMETERS
//   NREQ  4  number of requesters (2..8)
//   NREG  8  number of registers in the bank (<= 2**AW)
//   AW    3  register address width
//   DW    8  register data width
// PORTS
//   clk      in   1         clock, rising edge
//   reset_n  in   1         asynchronous active-low reset
//   req      in   NREQ      per-requester write request; held high until ack
//   lock     in   NREQ      per-requester burst lock; sampled while that requester owns the bank
//   addr     in   NREQ*AW   per-requester register address, slice i = [i*AW +: AW]
//   data     in   NREQ*DW   per-requester write data, slice i = [i*DW +: DW]
//   gnt      out  NREQ      registered one-hot owner indication; all zero when IDLE
//   ack      out  NREQ      registered one-cycle pulse to the owner; asserted in the cycle its write is issued
//   reg_en   out  NREG      registered one-hot enable to register i; at most one bit set
//   reg_d    out  DW        registered write data to all registers in the bank
//   busy     out  1         1 whenever state != IDLE
// BEHAVIOUR
//   Reset (asynchronous, takes effect immediately):
//     - state=IDLE; gnt, ack, reg_en, reg_d and busy = 0; rr_ptr = 0.
//     - A write in flight is dropped: reg_en falls at once, so the bank sees no enable.
//   States:
//     - IDLE: if |req, pick the winner w = first set req at or after rr_ptr, wrapping.
//       Latch addr[w] and data[w]. Set gnt=onehot(w), reg_en=onehot(addr[w]), reg_d=data[w], ack[w]=1. Go to WRITE.
//       If no req, stay in IDLE.
//     - WRITE: outputs are live for exactly this one cycle; the bank captures at the closing edge.
//       - If lock[w]=1, go to LOCKED and clear reg_en and ack.
//       - If lock[w]=0, go to IDLE, clear gnt, reg_en and ack, and set rr_ptr=(w+1)%NREQ.
//     - LOCKED: gnt is held; other requesters are ignored.
//       - If req[w]=1, latch the new addr and data, pulse ack and reg_en as above, and go to WRITE.
//       - Else if lock[w]=0, go to IDLE and set rr_ptr=(w+1)%NREQ.
//       - Otherwise stay in LOCKED.
//   Latency and throughput:
//     - req to reg_en/ack is 1 cycle. The register's d_out updates at the edge ending WRITE.
//     - Steady throughput is 1 write per 2 cycles, both for fresh grants and for bursts.
//   Handshake:
//     - A requester holds req, addr and data stable until it sees ack.
//     - On seeing ack it may drop req or present the next item.
//     - Inputs are ignored while in WRITE, so the stale req in the ack cycle never causes a double write.
//   Boundaries:
//     - Simultaneous requests: exactly one winner per the round-robin order; the losers keep waiting, with no ack.
//     - rr_ptr wraps from NREQ-1 to 0.
//     - addr >= NREG: ack is still pulsed, reg_en stays all-zero, and the write is discarded.
//     - The owner's req falling in LOCKED while lock stays high: the block waits indefinitely. Starvation is the requester's responsibility.
//     - lock of a non-owner has no effect.
//   Width rules: reg_d is a plain copy of the DW-bit input (no arithmetic); reg_en is the decode of the AW-bit addr.
// STRUCTURE
//   Shared constants file reg_ctrl_pkg:
//     - state encodings ST_IDLE=2'd0, ST_WRITE=2'd1, ST_LOCKED=2'd2
//     - default widths DW=8, AW=3
//   Sub-module rr_arbiter:
//     - combinational round-robin picker
//     - inputs req[NREQ] and ptr; outputs one-hot win[NREQ] and win_idx
//   Top level: FSM, the latch registers for addr/data/owner, output registers, and the rr_ptr update.
// TESTING
//   - Reset, idle: req=0 for 10 cycles. Then gnt=0, ack=0, reg_en=0, busy=0.
//   - Single write: req[2]=1, addr=3'd5, data=8'hA5. Next cycle reg_en=8'b0010_0000, reg_d=8'hA5, ack[2]=1, gnt=4'b0100.
//     On the following cycle register 5 holds 8'hA5 and the block is back in IDLE.
//   - Round-robin: req=4'b1111 held with lock=0. The ack order is 0,1,2,3,0. Each acked requester re-raises req the cycle after its ack.
//   - Burst lock: req[1] and lock[1] high, with 3 writes to addrs 0,1,2 (data 8'h11, 8'h22, 8'h33) while req[0] is held.
//     All three acks go to requester 1, 2 cycles apart. Requester 0 is granted only after lock[1] falls.
//   - Async reset mid-write: assert reset_n=0 during WRITE, between edges. reg_en and ack fall immediately and the target register stays 0.
//   - Out-of-range: NREG=6, addr=3'd7. ack pulses, reg_en=0, and no register changes.

Source files
------------

// File: rtl/reg_ctrl_pkg.sv
// Shared constants for the register-bank write path: FSM encodings and
// default data/address widths.
package reg_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam int DEF_DW = 8;
   localparam int DEF_AW = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping past NREQ-1 back to 0.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] win,
   output logic [PW-1:0]   win_idx
);

   logic w_found;

   // Position ptr+k in the circular order, without a modulo operator.
   function automatic int wrap_idx(input int p, input int k);
      int j;
      j = p + k;
      if (j >= NREQ) j = j - NREQ;
      return j;
   endfunction

   // Scan from ptr upward and keep only the first hit.
   always_comb begin
      win     = '0;
      win_idx = '0;
      w_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && req[wrap_idx(int'(ptr), k)]) begin
            w_found                   = 1'b1;
            win[wrap_idx(int'(ptr), k)] = 1'b1;
            win_idx                   = PW'(wrap_idx(int'(ptr), k));
         end
      end
   end

endmodule

// File: rtl/reg_bank_wr_arbiter.sv
// Round-robin write arbiter in front of a bank of NREG registers. A winner's
// addr/data are latched and issued as a one-cycle one-hot reg_en plus reg_d,
// with ack returned to the winner in the same cycle. A held lock keeps the
// bank owned for back-to-back writes.
//
// Handshake: a requester keeps req/addr/data stable until it sees ack; the
// write is issued in the ack cycle (WRITE state), during which all inputs are
// ignored, so a req still high in that cycle never produces a second write.
module reg_bank_wr_arbiter
   import reg_ctrl_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int NREG = 8,
   parameter int AW   = DEF_AW,
   parameter int DW   = DEF_DW
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   lock,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] data,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   ack,
   output logic [NREG-1:0]   reg_en,
   output logic [DW-1:0]     reg_d,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   localparam int PW = $clog2(NREQ);

   state_t          r_state;
   state_t          w_next_state;
   logic [PW-1:0]   r_owner;
   logic [PW-1:0]   r_ptr;
   logic [NREQ-1:0] r_gnt;
   logic [NREQ-1:0] r_ack;
   logic [NREG-1:0] r_reg_en;
   logic [DW-1:0]   r_data;

   logic [NREQ-1:0] w_win;
   logic [PW-1:0]   w_win_idx;
   logic [PW-1:0]   w_src_idx;
   logic [NREQ-1:0] w_src_oh;
   logic [AW-1:0]   w_src_addr;
   logic [DW-1:0]   w_src_data;
   logic [NREG-1:0] w_en_dec;
   logic [PW-1:0]   w_ptr_next;
   logic            w_issue;
   logic            w_release;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr (
      .req     (req),
      .ptr     (r_ptr),
      .win     (w_win),
      .win_idx (w_win_idx)
   );

   assign w_src_addr = addr[int'(w_src_idx)*AW +: AW];
   assign w_src_data = data[int'(w_src_idx)*DW +: DW];
   assign w_ptr_next = (int'(r_owner) == NREQ-1) ? '0 : r_owner + 1'b1;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next_state;
   end

   // Next-state logic: WRITE always lasts one cycle; LOCKED waits on the owner.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (|req) w_next_state = ST_WRITE;
         ST_WRITE:  w_next_state = lock[r_owner] ? ST_LOCKED : ST_IDLE;
         ST_LOCKED: begin
            if (req[r_owner])        w_next_state = ST_WRITE;
            else if (!lock[r_owner]) w_next_state = ST_IDLE;
         end
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // Output control: who is issued this cycle, and when ownership is released.
   always_comb begin
      w_issue   = 1'b0;
      w_release = 1'b0;
      w_src_idx = r_owner;
      w_src_oh  = r_gnt;
      case (r_state)
         ST_IDLE: begin
            w_issue   = |req;
            w_src_idx = w_win_idx;
            w_src_oh  = w_win;
         end
         ST_WRITE:  w_release = !lock[r_owner];
         ST_LOCKED: begin
            w_issue   = req[r_owner];
            w_release = !req[r_owner] && !lock[r_owner];
         end
         default: ;
      endcase
   end

   // Address decode; an out-of-range address yields no enable at all.
   always_comb begin
      w_en_dec = '0;
      if (int'(w_src_addr) < NREG) w_en_dec[w_src_addr] = 1'b1;
   end

   // Latched owner/data and registered outputs; ack and reg_en are single pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_owner  <= '0;
         r_ptr    <= '0;
         r_gnt    <= '0;
         r_ack    <= '0;
         r_reg_en <= '0;
         r_data   <= '0;
      end else if (w_issue) begin
         r_owner  <= w_src_idx;
         r_gnt    <= w_src_oh;
         r_ack    <= w_src_oh;
         r_reg_en <= w_en_dec;
         r_data   <= w_src_data;
      end else begin
         r_ack    <= '0;
         r_reg_en <= '0;
         if (w_release) begin
            r_gnt <= '0;
            r_ptr <= w_ptr_next;
         end
      end
   end

   assign gnt       = r_gnt;
   assign ack       = r_ack;
   assign reg_en    = r_reg_en;
   assign reg_d     = r_data;
   assign busy      = (r_state != ST_IDLE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Directed bench for reg_bank_wr_arbiter: an 8-register instance plus a
// 6-register instance (for out-of-range addresses) sharing the same stimulus,
// each feeding a simple register bank model.
module tb_reg_bank_wr_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        bank_clr_n = 1'b0;
   logic [3:0]  req = '0;
   logic [3:0]  lock = '0;
   logic [11:0] addr = '0;
   logic [31:0] data = '0;

   logic [3:0]  gnt, ack, gnt6, ack6;
   logic [7:0]  reg_en, reg_d, reg_d6;
   logic [5:0]  reg_en6;
   logic        busy, busy6;
   logic [1:0]  dbg_state, dbg_state6;

   logic [7:0][7:0] bank;
   logic [5:0][7:0] bank6;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   reg_bank_wr_arbiter #(.NREQ(4), .NREG(8), .AW(3), .DW(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .addr(addr), .data(data),
      .gnt(gnt), .ack(ack), .reg_en(reg_en), .reg_d(reg_d), .busy(busy), .dbg_state(dbg_state)
   );

   reg_bank_wr_arbiter #(.NREQ(4), .NREG(6), .AW(3), .DW(8)) u_dut6 (
      .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .addr(addr), .data(data),
      .gnt(gnt6), .ack(ack6), .reg_en(reg_en6), .reg_d(reg_d6), .busy(busy6), .dbg_state(dbg_state6)
   );

   // Register bank models; cleared only at time zero so DUT resets cannot hide writes.
   always_ff @(posedge clk or negedge bank_clr_n) begin
      if (!bank_clr_n) bank <= '0;
      else for (int i = 0; i < 8; i++) if (reg_en[i]) bank[i] <= reg_d;
   end

   always_ff @(posedge clk or negedge bank_clr_n) begin
      if (!bank_clr_n) bank6 <= '0;
      else for (int i = 0; i < 6; i++) if (reg_en6[i]) bank6[i] <= reg_d6;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_item(input int i, input logic [2:0] a, input logic [7:0] d);
      addr[i*3 +: 3] = a;
      data[i*8 +: 8] = d;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req     = '0;
      lock    = '0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   logic [3:0]      ack_log [5];
   int              ack_cyc [5];
   int              n_acks;
   logic [3:0]      pending;
   logic [5:0][7:0] snap6;

   initial begin
      // Reset and idle
      #2 bank_clr_n = 1'b1;
      tick();
      check("rst_gnt", gnt, 0);
      check("rst_reg_en", reg_en, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("idle_gnt", gnt, 0);
      check("idle_ack", ack, 0);
      check("idle_reg_en", reg_en, 0);
      check("idle_busy", busy, 0);

      // Single write: requester 2, addr 5, data A5
      set_item(2, 3'd5, 8'hA5);
      req = 4'b0100;
      tick();
      check("single_reg_en", reg_en, 8'b0010_0000);
      check("single_reg_d", reg_d, 8'hA5);
      check("single_ack", ack, 4'b0100);
      check("single_gnt", gnt, 4'b0100);
      check("single_busy", busy, 1);
      req = '0;
      tick();
      check("single_bank5", bank[5], 8'hA5);
      check("single_idle_state", dbg_state, 0);
      check("single_idle_ack", ack, 0);
      check("single_idle_gnt", gnt, 0);

      // Round-robin with all four requesting, no lock
      do_reset();
      for (int i = 0; i < 4; i++) set_item(i, 3'(i), 8'(8'h40 + i));
      req     = 4'hF;
      n_acks  = 0;
      pending = '0;
      for (int c = 0; c < 20 && n_acks < 5; c++) begin
         tick();
         req     = req | pending;
         pending = '0;
         if (ack != 0) begin
            ack_log[n_acks] = ack;
            ack_cyc[n_acks] = c;
            n_acks++;
            pending = ack;
            req     = req & ~ack;
         end
      end
      check("rr_ack_count", n_acks, 5);
      check("rr_ack0", ack_log[0], 4'b0001);
      check("rr_ack1", ack_log[1], 4'b0010);
      check("rr_ack2", ack_log[2], 4'b0100);
      check("rr_ack3", ack_log[3], 4'b1000);
      check("rr_ack4_wrap", ack_log[4], 4'b0001);
      for (int k = 1; k < 5; k++) check("rr_spacing", ack_cyc[k] - ack_cyc[k-1], 2);
      req = '0;
      tick();
      tick();
      check("rr_bank0", bank[0], 8'h40);
      check("rr_bank1", bank[1], 8'h41);
      check("rr_bank2", bank[2], 8'h42);
      check("rr_bank3", bank[3], 8'h43);

      // Burst lock by requester 1 while requester 0 waits
      do_reset();
      set_item(1, 3'd0, 8'h11);
      req  = 4'b0010;
      lock = 4'b0010;
      tick();
      check("burst1_ack", ack, 4'b0010);
      check("burst1_reg_en", reg_en, 8'h01);
      check("burst1_reg_d", reg_d, 8'h11);
      set_item(0, 3'd7, 8'h77);
      set_item(1, 3'd1, 8'h22);
      req = 4'b0011;
      tick();
      check("burst_locked_state", dbg_state, 2);
      check("burst_locked_ack", ack, 0);
      check("burst_locked_reg_en", reg_en, 0);
      check("burst_locked_gnt", gnt, 4'b0010);
      tick();
      check("burst2_ack", ack, 4'b0010);
      check("burst2_reg_en", reg_en, 8'h02);
      check("burst2_reg_d", reg_d, 8'h22);
      set_item(1, 3'd2, 8'h33);
      tick();
      check("burst_locked2_ack", ack, 0);
      tick();
      check("burst3_ack", ack, 4'b0010);
      check("burst3_reg_en", reg_en, 8'h04);
      check("burst3_reg_d", reg_d, 8'h33);
      req  = 4'b0001;
      lock = 4'b0000;
      tick();
      check("burst_release_gnt", gnt, 0);
      check("burst_release_busy", busy, 0);
      tick();
      check("burst_req0_ack", ack, 4'b0001);
      check("burst_req0_gnt", gnt, 4'b0001);
      check("burst_req0_reg_en", reg_en, 8'h80);
      check("burst_req0_reg_d", reg_d, 8'h77);
      req = '0;
      tick();
      check("burst_bank0", bank[0], 8'h11);
      check("burst_bank1", bank[1], 8'h22);
      check("burst_bank2", bank[2], 8'h33);
      check("burst_bank7", bank[7], 8'h77);

      // Asynchronous reset in the middle of a WRITE cycle
      do_reset();
      set_item(3, 3'd4, 8'h5C);
      req = 4'b1000;
      tick();
      check("arst_pre_ack", ack, 4'b1000);
      #3 reset_n = 1'b0;
      #1;
      check("arst_ack", ack, 0);
      check("arst_reg_en", reg_en, 0);
      check("arst_busy", busy, 0);
      check("arst_gnt", gnt, 0);
      tick();
      check("arst_bank4", bank[4], 0);
      req     = '0;
      reset_n = 1'b1;
      tick();
      check("arst_bank4_after", bank[4], 0);

      // Out-of-range address on the 6-register instance
      do_reset();
      set_item(0, 3'd7, 8'hEE);
      snap6 = bank6;
      req   = 4'b0001;
      tick();
      check("oor_ack", ack6, 4'b0001);
      check("oor_reg_en", reg_en6, 0);
      check("oor_gnt", gnt6, 4'b0001);
      req = '0;
      tick();
      check("oor_bank_unchanged", bank6, snap6);
      check("oor_busy", busy6, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
